hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the two-stage hazard_detection unit. Replaces fixed EXE/MEM destination compares with a per-register countdown scoreboard.
- Supports variable result latency per instruction (ALU, load, multi-cycle ops), a freeze input and a flush input.
- Sits in the ID stage; drives the pipeline stall (IF/ID hold plus bubble into ID/EXE).

Parameters:
REG_ADDR_W, 5, register index width
NUM_REGS, 32, architectural registers tracked (2**REG_ADDR_W)
LAT_W, 3, width of the per-register countdown and of issue_lat (max latency 2**LAT_W-1)
ZERO_REG_EN, 1, 1 = register 0 is hardwired and never marked busy
STAT_W, 16, width of the saturating stall-cycle counter

Ports:
clk  in  1  pipeline clock
rst  in  1  asynchronous active-low reset
src1_ID  in  REG_ADDR_W  first source of the instruction in ID
src2_ID  in  REG_ADDR_W  second source of the instruction in ID
is_imm  in  1  src2 unused (immediate form)
dest_ID  in  REG_ADDR_W  destination of the instruction in ID
WB_EN_ID  in  1  instruction in ID writes a register
issue_lat  in  LAT_W  stall cycles a dependant needs after this instruction issues
freeze  in  1  whole pipeline held (e.g. memory wait)
flush  in  1  branch taken; discard ID and younger state
hazard_detected  out  1  stall the ID instruction this cycle (combinational)
busy_vec  out  NUM_REGS  bit r = 1 when counter[r] != 0
stall_cycles  out  STAT_W  saturating count of cycles with hazard_detected=1

Behaviour:
- State: counter[r] (LAT_W bits) for each register; stall_cycles register.
- Reset (rst=0, async): all counters 0, stall_cycles 0. Outputs follow: hazard_detected=0, busy_vec=0.
- hazard_detected = (counter[src1_ID]!=0) | (~is_imm & counter[src2_ID]!=0). This uses current (pre-update) state and no same-cycle bypass.
- ZERO_REG_EN=1: counter[0] is tied 0, and writes to it are ignored.
- issue = WB_EN_ID & ~hazard_detected & ~freeze & ~flush.
- Per-cycle update, priority high to low:
  1. flush: every counter <= 0. Everything in flight is treated as resolved.
  2. freeze: all counters hold; no issue.
  3. otherwise: every nonzero counter decrements by 1. If issue, then counter[dest_ID] <= max(issue_lat, counter[dest_ID]-1), which keeps the longer of the WAW pair.
- issue_lat = 0: the destination is not marked busy (full forwarding case).
- Source equal to dest_ID within the same instruction: no self-hazard, because the check uses pre-issue state.
- Latency contract:
  - Consumer immediately after producer with issue_lat=N stalls exactly N cycles (absent freeze).
  - Each freeze cycle extends the stall by one cycle.
  - Reference values: no-forwarding ALU op N=2 (matches legacy EXE+MEM behaviour); forwarded ALU N=0; forwarded load N=1.
- Counters never underflow and never wrap; decrement applies only when the counter is nonzero.
- stall_cycles increments when hazard_detected=1 and ~freeze. It saturates at all-ones and is cleared only by reset.
- Reset asserted mid-stall: hazard_detected drops to 0 immediately (asynchronous).

Decomposition:
- Shared pipeline package holds: REG_ADDR_W, LAT_W, and the latency constants LAT_ALU_NOFWD=2, LAT_ALU_FWD=0, LAT_LOAD_FWD=1.
- One sub-module, scoreboard_entry: a single counter with decrement, load-max, flush and hold. It is instantiated NUM_REGS times via generate, and entry 0 is omitted when ZERO_REG_EN=1.
- The source read muxes and stall logic stay in the top module.

Test Plan:
- Reset then idle, src1=3/src2=4 → hazard_detected=0, busy_vec=0, stall_cycles=0.
- Issue dest=5 with issue_lat=2, next instruction src1=5 → hazard_detected=1 for exactly 2 cycles, then 0; stall_cycles=2.
- Issue dest=7 with issue_lat=1, consumer has src2=7 and is_imm=1 → no stall. Repeat with is_imm=0 → 1 stall cycle.
- Load dest=9 (lat 3), then a second writer of dest=9 (lat 1) issued before the first resolves → the max rule keeps counter[9] at 2 (3-1 vs 1); a consumer stalls the full remaining time.
- Consumer stalled on dest=5 (counter 2), freeze for 3 cycles → counter stays 2 and the stall lasts 5 cycles total. Assert flush mid-stall → counters all 0 and hazard_detected=0 the next cycle.
- Issue dest=0 with lat 3 (ZERO_REG_EN=1) → busy_vec[0]=0 and a src1=0 consumer never stalls. Force 2**STAT_W+5 stall cycles → stall_cycles holds at all-ones.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// hazard_scoreboard_pkg: shared pipeline widths and reference result latencies
package hazard_scoreboard_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int LAT_W = 3;
  localparam logic [LAT_W-1:0] LAT_ALU_NOFWD = 3'd2;
  localparam logic [LAT_W-1:0] LAT_ALU_FWD = 3'd0;
  localparam logic [LAT_W-1:0] LAT_LOAD_FWD = 3'd1;
endpackage

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: ID-stage request and stall response bundle
interface hazard_scoreboard_if #(
  parameter int REG_ADDR_W = hazard_scoreboard_pkg::REG_ADDR_W,
  parameter int NUM_REGS = 2**REG_ADDR_W,
  parameter int LAT_W = hazard_scoreboard_pkg::LAT_W,
  parameter int STAT_W = 16
);
  logic [REG_ADDR_W-1:0] src1_ID;
  logic [REG_ADDR_W-1:0] src2_ID;
  logic is_imm;
  logic [REG_ADDR_W-1:0] dest_ID;
  logic WB_EN_ID;
  logic [LAT_W-1:0] issue_lat;
  logic freeze;
  logic flush;
  logic hazard_detected;
  logic [NUM_REGS-1:0] busy_vec;
  logic [STAT_W-1:0] stall_cycles;
  modport master (
    output src1_ID, src2_ID, is_imm, dest_ID, WB_EN_ID, issue_lat, freeze, flush,
    input hazard_detected, busy_vec, stall_cycles
  );
  modport slave (
    input src1_ID, src2_ID, is_imm, dest_ID, WB_EN_ID, issue_lat, freeze, flush,
    output hazard_detected, busy_vec, stall_cycles
  );
endinterface

// File: rtl/hazard_scoreboard_entry.sv
// scoreboard_entry: one register's countdown with flush, hold, decrement and load-max
module scoreboard_entry #(
  parameter int LAT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             freeze,
  input  logic             load,
  input  logic [LAT_W-1:0] lat,
  output logic [LAT_W-1:0] count
);
  logic [LAT_W-1:0] dec, nxt;
  always_comb begin
    dec = (count != '0) ? count - 1'b1 : count;
    nxt = flush ? '0 : freeze ? count : (load && lat > dec) ? lat : dec;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) count <= '0;
    else count <= nxt;
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register countdown scoreboard driving the ID-stage stall
module hazard_scoreboard #(
  parameter int REG_ADDR_W = hazard_scoreboard_pkg::REG_ADDR_W,
  parameter int NUM_REGS = 2**REG_ADDR_W,
  parameter int LAT_W = hazard_scoreboard_pkg::LAT_W,
  parameter int ZERO_REG_EN = 1,
  parameter int STAT_W = 16
) (
  input logic clk,
  input logic rst,
  hazard_scoreboard_if.slave sb
);
  logic [LAT_W-1:0] cnt [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [STAT_W-1:0] stall;
  logic hz, issue;
  for (genvar r = 0; r < NUM_REGS; r++) begin : g_ent
    if (ZERO_REG_EN != 0 && r == 0) begin : g_zero
      assign cnt[r] = '0;
    end else begin : g_cnt
      scoreboard_entry #(.LAT_W(LAT_W)) u_entry (
        .clk(clk),
        .rst(rst),
        .flush(sb.flush),
        .freeze(sb.freeze),
        .load(issue && sb.dest_ID == REG_ADDR_W'(r)),
        .lat(sb.issue_lat),
        .count(cnt[r])
      );
    end
    assign busy[r] = |cnt[r];
  end
  // Pre-update state only: a source matching its own dest never self-stalls.
  assign hz = busy[sb.src1_ID] | (~sb.is_imm & busy[sb.src2_ID]);
  assign issue = sb.WB_EN_ID & ~hz & ~sb.freeze & ~sb.flush;
  always_ff @(posedge clk or negedge rst)
    if (!rst) stall <= '0;
    else if (hz && !sb.freeze && !(&stall)) stall <= stall + 1'b1;
  assign sb.hazard_detected = hz;
  assign sb.busy_vec = busy;
  assign sb.stall_cycles = stall;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed scoreboard-queue bench for hazard_scoreboard
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;
  localparam int SW = 8;
  typedef struct {
    string tag;
    logic hz;
    logic [31:0] busy;
    logic [SW-1:0] st;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  hazard_scoreboard_if #(.REG_ADDR_W(REG_ADDR_W), .NUM_REGS(32), .LAT_W(LAT_W), .STAT_W(SW)) sbif ();
  hazard_scoreboard #(.STAT_W(SW)) dut (.clk(clk), .rst(rst), .sb(sbif.slave));
  initial begin
    #200000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "watchdog");
  end
  task automatic compare();
    exp_t e;
    e = q.pop_front();
    checks++;
    assert (sbif.hazard_detected === e.hz) else begin
      errors++;
      $error("FAIL %s hazard got %0b want %0b", e.tag, sbif.hazard_detected, e.hz);
    end
    checks++;
    assert (sbif.busy_vec === e.busy) else begin
      errors++;
      $error("FAIL %s busy_vec got %h want %h", e.tag, sbif.busy_vec, e.busy);
    end
    checks++;
    assert (sbif.stall_cycles === e.st) else begin
      errors++;
      $error("FAIL %s stall_cycles got %0d want %0d", e.tag, sbif.stall_cycles, e.st);
    end
  endtask
  task automatic step(input logic [4:0] s1, input logic [4:0] s2, input logic imm,
                      input logic [4:0] d, input logic wb, input logic [2:0] lat,
                      input logic fz, input logic fl, input logic hz,
                      input logic [31:0] busy, input logic [SW-1:0] st, input string tag);
    sbif.src1_ID = s1;
    sbif.src2_ID = s2;
    sbif.is_imm = imm;
    sbif.dest_ID = d;
    sbif.WB_EN_ID = wb;
    sbif.issue_lat = lat;
    sbif.freeze = fz;
    sbif.flush = fl;
    q.push_back('{tag, hz, busy, st});
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
  endtask
  task automatic prod(input logic [4:0] d, input logic [2:0] lat, input logic [SW-1:0] st, input string tag);
    step(5'd1, 5'd2, 1'b0, d, 1'b1, lat, 1'b0, 1'b0, 1'b0, 32'h0, st, tag);
  endtask
  task automatic cons(input logic [4:0] s1, input logic [4:0] s2, input logic imm, input logic fz,
                      input logic fl, input logic hz, input logic [31:0] busy,
                      input logic [SW-1:0] st, input string tag);
    step(s1, s2, imm, 5'd0, 1'b0, 3'd0, fz, fl, hz, busy, st, tag);
  endtask
  initial begin
    logic [SW-1:0] st_exp;
    sbif.src1_ID = 5'd3;
    sbif.src2_ID = 5'd4;
    sbif.is_imm = 1'b0;
    sbif.dest_ID = 5'd0;
    sbif.WB_EN_ID = 1'b0;
    sbif.issue_lat = 3'd0;
    sbif.freeze = 1'b0;
    sbif.flush = 1'b0;
    @(negedge clk);
    q.push_back('{"reset", 1'b0, 32'h0, 8'd0});
    compare();
    rst = 1'b1;
    @(posedge clk);
    #1;
    cons(5'd3, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 8'd0, "idle");
    prod(5'd5, LAT_ALU_NOFWD, 8'd0, "p5_lat2");
    cons(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h20, 8'd0, "c5_s1");
    cons(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h20, 8'd1, "c5_s2");
    step(5'd5, 5'd0, 1'b1, 5'd6, 1'b1, LAT_ALU_FWD, 1'b0, 1'b0, 1'b0, 32'h0, 8'd2, "c5_go_lat0");
    prod(5'd7, LAT_LOAD_FWD, 8'd2, "p7_lat1");
    cons(5'd1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 32'h80, 8'd2, "c7_imm");
    prod(5'd7, LAT_LOAD_FWD, 8'd2, "p7_again");
    cons(5'd1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1, 32'h80, 8'd2, "c7_reg");
    cons(5'd1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 8'd3, "c7_done");
    prod(5'd9, 3'd3, 8'd3, "p9_lat3");
    step(5'd1, 5'd2, 1'b0, 5'd9, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 32'h200, 8'd3, "p9_waw");
    cons(5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h200, 8'd3, "c9_s1");
    cons(5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h200, 8'd4, "c9_s2");
    cons(5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 8'd5, "c9_done");
    prod(5'd5, LAT_ALU_NOFWD, 8'd5, "p5_frz");
    cons(5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h20, 8'd5, "frz1");
    cons(5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h20, 8'd5, "frz2");
    cons(5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h20, 8'd5, "frz3");
    cons(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h20, 8'd5, "frz_s1");
    cons(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h20, 8'd6, "frz_s2");
    cons(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 8'd7, "frz_done");
    prod(5'd5, 3'd3, 8'd7, "p5_fl");
    cons(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h20, 8'd7, "fl_s1");
    cons(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h20, 8'd8, "fl_assert");
    cons(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 8'd9, "fl_after");
    prod(5'd0, 3'd3, 8'd9, "p0_lat3");
    cons(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 8'd9, "c0");
    step(5'd10, 5'd10, 1'b0, 5'd10, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 32'h0, 8'd9, "self_src");
    cons(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 32'h400, 8'd9, "r10_busy1");
    cons(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 32'h400, 8'd9, "r10_busy2");
    cons(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 8'd9, "r10_free");
    st_exp = 8'd9;
    for (int i = 0; i < 40; i++) begin
      prod(5'd5, 3'd7, st_exp, "sat_prod");
      for (int k = 0; k < 7; k++) begin
        cons(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h20, st_exp, "sat_stall");
        st_exp = (st_exp == 8'hff) ? st_exp : st_exp + 8'd1;
      end
    end
    cons(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 8'hff, "sat_hold");
    prod(5'd5, 3'd3, 8'hff, "p5_rst");
    cons(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h20, 8'hff, "rst_pre");
    #2 rst = 1'b0;
    #1;
    q.push_back('{"rst_async", 1'b0, 32'h0, 8'd0});
    compare();
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    cons(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 8'd0, "rst_after");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
